// File: rtl/opacc_pkg.sv
// Shared types and constants for the opacc tile mover.
// Holds the command/state enums, the stall-counter width and small
// decode helpers used by the sequencer.
package opacc_pkg;

    // Command opcodes as they appear on cmd_op.
    typedef enum logic [1:0] {
        MV_LOAD  = 2'b00,
        MV_STORE = 2'b01,
        MV_SWAP  = 2'b10,
        MV_RSVD  = 2'b11
    } mover_op_e;

    // Sequencer states: idle waiting for a command, or moving ml rows.
    typedef enum logic {
        MV_IDLE = 1'b0,
        MV_RUN  = 1'b1
    } mover_state_e;

    // Width of the optional stall counters.
    localparam int unsigned STALL_CNT_W = 32;

    // Commands that consume rows from the input stream.
    function automatic logic op_needs_in(input mover_op_e op);
        return (op == MV_LOAD) || (op == MV_SWAP);
    endfunction

    // Commands that produce rows on the output stream.
    function automatic logic op_needs_out(input mover_op_e op);
        return (op == MV_STORE) || (op == MV_SWAP);
    endfunction

endpackage

// File: rtl/opacc_row_buf.sv
// Single-entry valid/ready row register with a last flag.
// Output stage of the tile mover: a drained row is written here one cycle
// after its beat and held until the downstream consumer takes it.
//
// Handshake: a row transfers on any rising clk where valid && ready are both
// high; valid never drops without that transfer, and data/last are stable
// while valid is high and ready is low. A load in the same cycle as a pop
// replaces the entry, so the stage sustains one row per cycle.
module opacc_row_buf #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    output logic         ok,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         last
);

    // The entry may be (re)written when it is empty or being popped now.
    assign ok = !valid || ready;

    // Entry register: load wins over pop; a pop without a load empties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/opacc_tile_mover.sv
// C-tile load/drain sequencer for the outer-product accumulator.
// Runs one LOAD / STORE / SWAP command per tile, always ml row beats:
// each beat shifts one row into the opacc (acc_ci) and, for STORE/SWAP,
// captures the row falling out (acc_co) into the output register.
// Rows therefore leave in the order they were loaded.
// Optional feature macro: OPACC_TILE_MOVER_STALL_CNT_EN builds the
// saturating input/output stall counters; otherwise both ports read 0.
module opacc_tile_mover
    import opacc_pkg::*;
#(
    parameter  int nregs = 2,
    parameter  int vl    = 4,
    parameter  int ml    = 4,
    parameter  int XLEN  = 64,
    localparam int AW    = (nregs > 1) ? $clog2(nregs) : 1,
    localparam int RW    = vl * XLEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [AW-1:0]          cmd_addr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RW-1:0]          in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RW-1:0]          out_data,
    output logic                   out_last,
    output logic                   acc_c_valid,
    output logic [AW-1:0]          acc_ci_addr,
    output logic [RW-1:0]          acc_ci,
    input  logic [RW-1:0]          acc_co,
    output logic                   busy,
    output logic [AW-1:0]          busy_addr,
    output logic [STALL_CNT_W-1:0] stall_in_cnt,
    output logic [STALL_CNT_W-1:0] stall_out_cnt
);

    localparam int            CW       = (ml > 1) ? $clog2(ml) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ml - 1);

    mover_state_e  state_q, state_d;
    mover_op_e     op_q;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] cnt_q, cnt_d;

    logic needs_in;
    logic needs_out;
    logic run;
    logic out_ok;
    logic beat;
    logic cmd_fire;

    assign needs_in  = op_needs_in(op_q);
    assign needs_out = op_needs_out(op_q);
    assign run       = (state_q == MV_RUN);
    assign cmd_fire  = cmd_valid && cmd_ready;

    // Next state, beat qualification and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        beat      = 1'b0;
        busy      = 1'b0;
        case (state_q)
            MV_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cnt_d = '0;
                    // The reserved opcode is swallowed as a no-op.
                    if (mover_op_e'(cmd_op) != MV_RSVD) begin
                        state_d = MV_RUN;
                    end
                end
            end
            MV_RUN: begin
                busy     = 1'b1;
                beat     = (!needs_in || in_valid) && (!needs_out || out_ok);
                in_ready = needs_in && (!needs_out || out_ok);
                if (beat) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = MV_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = MV_IDLE;
        endcase
    end

    // State and beat counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the accepted command; the address also steers the opacc port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= MV_RSVD;
            addr_q <= '0;
        end else if (cmd_fire) begin
            op_q   <= mover_op_e'(cmd_op);
            addr_q <= cmd_addr;
        end
    end

    // STORE shifts zeros in, which leaves the tile cleared afterwards.
    assign acc_c_valid = beat;
    assign acc_ci      = (run && needs_in) ? in_data : '0;
    assign acc_ci_addr = addr_q;
    assign busy_addr   = addr_q;

    opacc_row_buf #(
        .W(RW)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (beat && needs_out),
        .load_data (acc_co),
        .load_last (cnt_q == CNT_LAST),
        .ok        (out_ok),
        .valid     (out_valid),
        .ready     (out_ready),
        .data      (out_data),
        .last      (out_last)
    );

`ifdef OPACC_TILE_MOVER_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_in_q;
    logic [STALL_CNT_W-1:0] stall_out_q;

    // Saturating counts of RUN cycles starved of input or blocked on output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_in_q  <= '0;
            stall_out_q <= '0;
        end else begin
            if (run && needs_in && !in_valid && (stall_in_q != '1)) begin
                stall_in_q <= stall_in_q + STALL_CNT_W'(1);
            end
            if (run && needs_out && !out_ok && (stall_out_q != '1)) begin
                stall_out_q <= stall_out_q + STALL_CNT_W'(1);
            end
        end
    end

    assign stall_in_cnt  = stall_in_q;
    assign stall_out_cnt = stall_out_q;
`else
    assign stall_in_cnt  = '0;
    assign stall_out_cnt = '0;
`endif

endmodule

// File: tb/tb_opacc_tile_mover.sv
// Self-checking bench for opacc_tile_mover (nregs=2, vl=4, ml=4, XLEN=64).
// Contains a behavioural opacc tile (shift register per register), a
// per-register content model of the tiles and an expected-row queue.
module tb_opacc_tile_mover;

    localparam int NREGS = 2;
    localparam int VL    = 4;
    localparam int ML    = 4;
    localparam int XLEN  = 64;
    localparam int RW    = VL * XLEN;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

`ifdef OPACC_TILE_MOVER_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef logic [RW:0] val_t;

    typedef struct {
        logic [1:0]    op;
        logic          addr;
        int            base;
        int            exp_beats;
        int            exp_pops;
        logic [RW-1:0] exp_row0;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [0:0]    cmd_addr;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic          out_last;
    logic          acc_c_valid;
    logic [0:0]    acc_ci_addr;
    logic [RW-1:0] acc_ci;
    logic [RW-1:0] acc_co;
    logic          busy;
    logic [0:0]    busy_addr;
    logic [31:0]   stall_in_cnt;
    logic [31:0]   stall_out_cnt;

    opacc_tile_mover #(
        .nregs(NREGS), .vl(VL), .ml(ML), .XLEN(XLEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .acc_c_valid   (acc_c_valid),
        .acc_ci_addr   (acc_ci_addr),
        .acc_ci        (acc_ci),
        .acc_co        (acc_co),
        .busy          (busy),
        .busy_addr     (busy_addr),
        .stall_in_cnt  (stall_in_cnt),
        .stall_out_cnt (stall_out_cnt)
    );

    // ---------------- opacc tile environment ----------------
    // Row ML-1 is the oldest row; c_valid shifts a new row in at row 0.
    logic [RW-1:0] tile_mem [NREGS][ML] = '{default: '0};
    always @(posedge clk) begin
        if (acc_c_valid) begin
            for (int i = ML - 1; i > 0; i--) tile_mem[acc_ci_addr][i] <= tile_mem[acc_ci_addr][i - 1];
            tile_mem[acc_ci_addr][0] <= acc_ci;
        end
    end
    assign acc_co = tile_mem[acc_ci_addr][ML - 1];

    // ---------------- reference model / scoreboard ----------------
    logic [RW-1:0] ref_tile [NREGS][ML];  // index 0 = first row out
    val_t          exp_q[$];              // {last, data}
    logic [RW-1:0] in_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int beats, pops, busy_cyc, first_beat, last_beat;
    int in_mode, rdy_mode;        // 0 steady, 1 random, 3 manual
    logic man_in_valid, man_out_ready;
    logic cur_addr, cur_needs_in, cmd_acc;
    logic last_busy, last_in_ready, last_out_valid, ov_seen;
    logic [RW-1:0] first_out;

    task automatic check(input string name, input val_t act, input val_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_row(input int base);
        logic [RW-1:0] r;
        r = '0;
        for (int j = 0; j < VL; j++) r[j*XLEN +: XLEN] = XLEN'(base + j);
        return r;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    // Entered at a falling edge: drive inputs, sample 1 time unit before
    // the rising edge, then return at the next falling edge.
    task automatic cycle();
        in_data = (in_q.size() > 0) ? in_q[0] : '0;
        case (in_mode)
            0:       in_valid = (in_q.size() > 0);
            1:       in_valid = (in_q.size() > 0) && ($urandom_range(0, 1) == 1);
            default: in_valid = (in_q.size() > 0) && man_in_valid;
        endcase
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = man_out_ready;
        endcase
        #4;
        if (cmd_valid && cmd_ready) cmd_acc = 1'b1;
        if (acc_c_valid) begin
            if (beats == 0) first_beat = cyc;
            last_beat = cyc;
            beats++;
            check("ci_addr", val_t'(acc_ci_addr), val_t'(cur_addr));
            check("acc_ci", val_t'(acc_ci), val_t'(cur_needs_in ? in_data : '0));
        end
        if (in_valid && in_ready) begin
            check("in_hs_beat", val_t'(acc_c_valid), val_t'(1));
            void'(in_q.pop_front());
        end
        if (out_valid) ov_seen = 1'b1;
        if (out_valid && out_ready) begin
            if (pops == 0) first_out = out_data;
            pops++;
            if (exp_q.size() == 0) check("out_extra", val_t'(1), val_t'(0));
            else check("out_row", {out_last, out_data}, exp_q.pop_front());
        end
        if (busy) begin
            busy_cyc++;
            check("busy_addr", val_t'(busy_addr), val_t'(cur_addr));
        end
        last_busy      = busy;
        last_in_ready  = in_ready;
        last_out_valid = out_valid;
        cyc++;
        @(negedge clk);
    endtask

    // Update the reference model, queue the rows and present the command.
    task automatic issue(input logic [1:0] op, input logic addr, input int base, input int max_wait);
        logic ni, no;
        ni = (op == OP_LOAD) || (op == OP_SWAP);
        no = (op == OP_STORE) || (op == OP_SWAP);
        if (no) for (int r = 0; r < ML; r++) exp_q.push_back({(r == ML - 1), ref_tile[addr][r]});
        if (ni) begin
            for (int r = 0; r < ML; r++) begin
                ref_tile[addr][r] = mk_row(base + r * VL);
                in_q.push_back(ref_tile[addr][r]);
            end
        end else if (op == OP_STORE) begin
            for (int r = 0; r < ML; r++) ref_tile[addr][r] = '0;
        end
        cur_addr     = addr;
        cur_needs_in = ni;
        cmd_acc      = 1'b0;
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_addr     = addr;
        for (int i = 0; i < max_wait && !cmd_acc; i++) cycle();
        check("cmd_accept", val_t'(cmd_acc), val_t'(1));
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (last_busy && n < limit);
        check("idle_timeout", val_t'(last_busy), val_t'(0));
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            cycle();
            n++;
        end
        check("drain_timeout", val_t'(exp_q.size()), val_t'(0));
    endtask

    task automatic clear_stats();
        beats = 0; pops = 0; busy_cyc = 0; first_beat = -1; last_beat = -1;
        ov_seen = 1'b0; first_out = '0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_valid"}, val_t'(out_valid), val_t'(0));
        check({tag, "_out_last"}, val_t'(out_last), val_t'(0));
        check({tag, "_out_data"}, val_t'(out_data), val_t'(0));
        check({tag, "_c_valid"}, val_t'(acc_c_valid), val_t'(0));
        check({tag, "_ci_addr"}, val_t'(acc_ci_addr), val_t'(0));
        check({tag, "_acc_ci"}, val_t'(acc_ci), val_t'(0));
        check({tag, "_busy"}, val_t'(busy), val_t'(0));
        check({tag, "_in_ready"}, val_t'(in_ready), val_t'(0));
        check({tag, "_stall_in"}, val_t'(stall_in_cnt), val_t'(0));
        check({tag, "_stall_out"}, val_t'(stall_out_cnt), val_t'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t vecs[6];
        logic [31:0] si0, so0;
        int k_done;

        vecs[0] = '{OP_LOAD,  1'b1, 1,  4, 0, RW'(0)};
        vecs[1] = '{OP_STORE, 1'b1, 0,  4, 4, mk_row(1)};
        vecs[2] = '{OP_STORE, 1'b1, 0,  4, 4, RW'(0)};
        vecs[3] = '{OP_RSVD,  1'b0, 0,  0, 0, RW'(0)};
        vecs[4] = '{OP_SWAP,  1'b1, 50, 4, 4, RW'(0)};
        vecs[5] = '{OP_STORE, 1'b1, 0,  4, 4, mk_row(50)};

        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_mode = 0; rdy_mode = 0; man_in_valid = 1'b0; man_out_ready = 1'b1;
        cur_addr = 1'b0; cur_needs_in = 1'b0; cmd_acc = 1'b0;
        last_busy = 1'b0; last_in_ready = 1'b0; last_out_valid = 1'b0;
        clear_stats();
        for (int a = 0; a < NREGS; a++) for (int r = 0; r < ML; r++) ref_tile[a][r] = '0;

        // Power-on reset.
        #2;
        check_reset("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("por_cmd_ready", val_t'(cmd_ready), val_t'(1));
        @(negedge clk);

        // Table of single commands, each run in isolation.
        for (int i = 0; i < 6; i++) begin
            clear_stats();
            in_mode = 0; rdy_mode = 0;
            issue(vecs[i].op, vecs[i].addr, vecs[i].base, 2);
            wait_idle(50);
            drain(50);
            check($sformatf("vec%0d_beats", i), val_t'(beats), val_t'(vecs[i].exp_beats));
            check($sformatf("vec%0d_pops", i), val_t'(pops), val_t'(vecs[i].exp_pops));
            check($sformatf("vec%0d_busy", i), val_t'(busy_cyc), val_t'(vecs[i].exp_beats));
            check($sformatf("vec%0d_out_seen", i), val_t'(ov_seen), val_t'(vecs[i].exp_pops > 0));
            if (vecs[i].exp_pops > 0)
                check($sformatf("vec%0d_row0", i), val_t'(first_out), val_t'(vecs[i].exp_row0));
            if (vecs[i].exp_beats > 0)
                check($sformatf("vec%0d_span", i), val_t'(last_beat - first_beat), val_t'(vecs[i].exp_beats - 1));
        end

        // Reset in the middle of a SWAP with a drained row pending.
        issue(OP_LOAD, 1'b0, 100, 2);
        wait_idle(50);
        rdy_mode = 3; man_out_ready = 1'b0;
        issue(OP_SWAP, 1'b0, 200, 2);
        cycle();
        cycle();
        check("pre_rst_out_valid", val_t'(out_valid), val_t'(1));
        check("pre_rst_busy", val_t'(busy), val_t'(1));
        #2 reset = 1'b1;
        #1;
        check_reset("mid");
        exp_q.delete();
        in_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_cmd_ready", val_t'(cmd_ready), val_t'(1));
        @(negedge clk);
        rdy_mode = 0;
        issue(OP_LOAD, 1'b0, 300, 2);
        wait_idle(50);

        // SWAP with the output blocked on RUN cycles 2..6.
        issue(OP_LOAD, 1'b0, 60, 2);
        wait_idle(50);
        drain(20);
        si0 = stall_in_cnt;
        so0 = stall_out_cnt;
        clear_stats();
        rdy_mode = 3; man_out_ready = 1'b1;
        issue(OP_SWAP, 1'b0, 70, 2);
        for (int k = 1; k <= 20; k++) begin
            man_out_ready = !(k >= 2 && k <= 6);
            cycle();
            if (k >= 2 && k <= 6) check("swap_in_ready_stall", val_t'(last_in_ready), val_t'(0));
            if (k == 6) check("swap_beats_pre", val_t'(beats), val_t'(1));
            if (!last_busy) break;
        end
        rdy_mode = 0;
        drain(20);
        check("swap_beats", val_t'(beats), val_t'(4));
        check("swap_pops", val_t'(pops), val_t'(4));
        check("swap_stall_out", val_t'(stall_out_cnt - so0), val_t'(STALL_EN ? 5 : 0));
        check("swap_stall_in", val_t'(stall_in_cnt - si0), val_t'(0));

        // LOAD with in_valid on RUN cycles 1, 4, 7, 10.
        si0 = stall_in_cnt;
        clear_stats();
        in_mode = 3; man_in_valid = 1'b0;
        issue(OP_LOAD, 1'b1, 80, 2);
        k_done = 0;
        for (int k = 1; k <= 16; k++) begin
            man_in_valid = (k % 3 == 1);
            cycle();
            if (!last_busy) begin
                k_done = k;
                break;
            end
        end
        in_mode = 0;
        check("pulse_beats", val_t'(beats), val_t'(4));
        check("pulse_busy", val_t'(busy_cyc), val_t'(10));
        check("pulse_done", val_t'(k_done), val_t'(11));
        check("pulse_stall_in", val_t'(stall_in_cnt - si0), val_t'(STALL_EN ? 6 : 0));

        // STORE, then LOAD accepted while the last drained row is pending.
        clear_stats();
        rdy_mode = 3; man_out_ready = 1'b1;
        issue(OP_STORE, 1'b1, 0, 2);
        for (int k = 1; k <= 4; k++) cycle();
        man_out_ready = 1'b0;
        check("b2b_store_pops", val_t'(pops), val_t'(3));
        check("b2b_pending", val_t'(out_valid), val_t'(1));
        beats = 0; busy_cyc = 0;
        issue(OP_LOAD, 1'b0, 90, 1);
        wait_idle(20);
        check("b2b_load_beats", val_t'(beats), val_t'(4));
        check("b2b_load_busy", val_t'(busy_cyc), val_t'(4));
        check("b2b_still_pending", val_t'(last_out_valid), val_t'(1));
        rdy_mode = 0;
        drain(20);
        check("b2b_pops", val_t'(pops), val_t'(4));

        // Randomized back-to-back commands against the reference model.
        in_mode = 1; rdy_mode = 1;
        for (int n = 0; n < 40; n++) begin
            issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(1000, 900000)), 2);
            wait_idle(200);
        end
        rdy_mode = 0;
        drain(50);
        check("final_exp_q", val_t'(exp_q.size()), val_t'(0));
        check("final_in_q", val_t'(in_q.size()), val_t'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
